axi_lite_bram_host: RTL and testbench

AXI4-Lite responder that turns host (PS) register transactions into cycles on the processor's shared BRAM port (`bram_din`, `shared_bram_addr`, `bram_wr_en`, `bram_dout`). It also owns a control register that holds the processor in reset while a program is loaded. It sits between the PS AXI interconnect and `pipelined_processor`. It is the only initiator on that port.

---
 rtl/axi_bram_host_pkg.sv | 10 +
 rtl/axi_lite_bram_host.sv | 152 +++++++++++++++
 tb/tb_axi_lite_bram_host.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_bram_host_pkg.sv
// Shared types and constants for the AXI4-Lite host bridge onto the processor's
// shared BRAM port.
package axi_bram_host_pkg;
  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_CAPTURE, RD_RESP
  } host_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         CTRL_OFFSET = 0;
endpackage

// File: rtl/axi_lite_bram_host.sv
// AXI4-Lite responder driving the processor's shared BRAM port, plus a CTRL
// register whose bit 0 holds the processor in reset while a program is loaded.
module axi_lite_bram_host
  import axi_bram_host_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SIZE    = 1024,
  parameter int NUM_COL = 4,
  parameter int ADDR_W  = $clog2(SIZE) + 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [WIDTH-1:0]        s_axi_wdata,
  input  logic [NUM_COL-1:0]      s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_W-1:0]       s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [WIDTH-1:0]        bram_din,
  output logic [$clog2(SIZE)+2:0] shared_bram_addr,
  output logic [NUM_COL-1:0]      bram_wr_en,
  input  logic [WIDTH-1:0]        bram_dout,
  output logic                    cpu_reset
);
  localparam int LOGSIZE = $clog2(SIZE);
  localparam int WA      = LOGSIZE + 1;  // word address incl. imem/dmem select

  host_state_t          state_q, state_d;
  logic                 ready_en_q;
  logic                 aw_held_q, w_held_q;
  logic                 aw_space_q, rd_space_q;
  logic [WA-1:0]        aw_word_q, rd_word_q;
  logic [WIDTH-1:0]     w_data_q, rdata_q;
  logic [NUM_COL-1:0]   w_strb_q;
  logic                 run_n_q, rr_wr_next_q;
  logic [LOGSIZE+2:0]   bram_addr_q;
  logic                 aw_hs, w_hs, ar_hs, wr_arb, wr_go;
  logic                 unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = ready_en_q & ~aw_held_q;
  assign s_axi_wready  = ready_en_q & ~w_held_q;
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;

  // A write being latched this cycle already counts for arbitration, so AW+W
  // arriving alongside AR lets the round-robin pointer decide, not latch timing.
  assign wr_arb        = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign s_axi_arready = ready_en_q & (state_q == IDLE) & ~(wr_arb & rr_wr_next_q);
  assign ar_hs         = s_axi_arvalid & s_axi_arready;
  assign wr_go         = (state_q == IDLE) & aw_held_q & w_held_q & ~ar_hs;

  assign s_axi_bresp      = RESP_OKAY;
  assign s_axi_rresp      = RESP_OKAY;
  assign s_axi_rdata      = rdata_q;
  assign bram_din         = w_data_q;
  assign shared_bram_addr = bram_addr_q;
  assign cpu_reset        = run_n_q;

  always_comb begin
    state_d      = state_q;
    bram_wr_en   = '0;
    s_axi_bvalid = 1'b0;
    s_axi_rvalid = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_go)      state_d = WR_ISSUE;
        else if (ar_hs) state_d = RD_ISSUE;
      end
      WR_ISSUE: begin
        if (!aw_space_q) bram_wr_en = w_strb_q;
        state_d = WR_RESP;
      end
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) state_d = IDLE;
      end
      RD_ISSUE:   state_d = RD_CAPTURE;
      RD_CAPTURE: state_d = RD_RESP;
      RD_RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ready_en_q   <= 1'b0;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      aw_space_q   <= 1'b0;
      aw_word_q    <= '0;
      rd_space_q   <= 1'b0;
      rd_word_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      rdata_q      <= '0;
      bram_addr_q  <= '0;
      run_n_q      <= 1'b1;
      rr_wr_next_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      if (aw_hs) begin
        aw_held_q  <= 1'b1;
        aw_space_q <= s_axi_awaddr[ADDR_W-1];
        aw_word_q  <= s_axi_awaddr[LOGSIZE+2:2];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (wr_go) begin
        rr_wr_next_q <= 1'b0;
        if (!aw_space_q) bram_addr_q <= {aw_word_q, 2'b00};
      end
      if (ar_hs) begin
        rr_wr_next_q <= 1'b1;
        rd_space_q   <= s_axi_araddr[ADDR_W-1];
        rd_word_q    <= s_axi_araddr[LOGSIZE+2:2];
        if (!s_axi_araddr[ADDR_W-1]) bram_addr_q <= {s_axi_araddr[LOGSIZE+2:2], 2'b00};
      end
      if (state_q == WR_ISSUE) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        if (aw_space_q && aw_word_q == WA'(CTRL_OFFSET) && w_strb_q[0])
          run_n_q <= w_data_q[0];
      end
      if (state_q == RD_CAPTURE) begin
        if (!rd_space_q)                       rdata_q <= bram_dout;
        else if (rd_word_q == WA'(CTRL_OFFSET)) rdata_q <= {{(WIDTH-1){1'b0}}, run_n_q};
        else                                   rdata_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_bram_host.sv
// Randomized self-checking bench for axi_lite_bram_host with a BRAM model on the
// shared port and a word/byte-level reference memory plus CTRL bit.
module tb_axi_lite_bram_host;
  localparam int WIDTH = 32, SIZE = 1024, NUM_COL = 4, LOGSIZE = 10, ADDR_W = 14;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0]  s_axi_awaddr = '0, s_axi_araddr = '0;
  logic               s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
  logic               s_axi_bready = 1'b0, s_axi_rready = 1'b0;
  logic [WIDTH-1:0]   s_axi_wdata = '0;
  logic [NUM_COL-1:0] s_axi_wstrb = '0;
  logic               s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid;
  logic [1:0]         s_axi_bresp, s_axi_rresp;
  logic [WIDTH-1:0]   s_axi_rdata, bram_din, bram_dout;
  logic [LOGSIZE+2:0] shared_bram_addr;
  logic [NUM_COL-1:0] bram_wr_en;
  logic               cpu_reset;

  axi_lite_bram_host #(.WIDTH(WIDTH), .SIZE(SIZE), .NUM_COL(NUM_COL)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .bram_din(bram_din),
    .shared_bram_addr(shared_bram_addr), .bram_wr_en(bram_wr_en), .bram_dout(bram_dout),
    .cpu_reset(cpu_reset)
  );

  // Shared-port BRAM: byte-enabled write, one-cycle read latency.
  logic [31:0] bram [int];
  int          we_cnt = 0;
  logic [3:0]  last_we = '0;
  always @(posedge clk) begin : bram_model
    int i;
    logic [31:0] w;
    i = int'(shared_bram_addr[12:2]);
    bram_dout <= bram.exists(i) ? bram[i] : 32'h0;
    if (bram_wr_en != 4'h0) begin
      w = bram.exists(i) ? bram[i] : 32'h0;
      for (int b = 0; b < 4; b++) if (bram_wr_en[b]) w[8*b +: 8] = bram_din[8*b +: 8];
      bram[i] = w;
      we_cnt++;
      last_we = bram_wr_en;
    end
  end

  // Reference: what a host should read back, from the address map alone.
  logic [31:0] ref_mem [int];
  logic        ref_ctrl = 1'b1;

  function automatic logic [31:0] ref_read(input logic [13:0] a);
    if (a[13]) return (a[12:2] == 11'd0) ? {31'd0, ref_ctrl} : 32'd0;
    return ref_mem.exists(int'(a[12:2])) ? ref_mem[int'(a[12:2])] : 32'd0;
  endfunction

  function automatic void ref_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (!a[13]) begin
      w = ref_read(a);
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[int'(a[12:2])] = w;
    end else if (a[12:2] == 11'd0 && s[0]) begin
      ref_ctrl = d[0];
    end
  endfunction

  int n_cmp = 0, n_bad = 0;
  time aw_t, ar_t;
  logic b_cpu_prev, b_cpu_now;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic aw_hs(input logic [13:0] a);
    bit done = 0;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (s_axi_awready) begin @(posedge clk); aw_t = $time; done = 1; end
    end
    #1 s_axi_awvalid = 1'b0;
    if (!done) chk("aw_timeout", 0, 1);
  endtask

  task automatic w_hs(input logic [31:0] d, input logic [3:0] s);
    bit done = 0;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (s_axi_wready) begin @(posedge clk); done = 1; end
    end
    #1 s_axi_wvalid = 1'b0;
    if (!done) chk("w_timeout", 0, 1);
  endtask

  task automatic ar_hs(input logic [13:0] a);
    bit done = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (s_axi_arready) begin @(posedge clk); ar_t = $time; done = 1; end
    end
    #1 s_axi_arvalid = 1'b0;
    if (!done) chk("ar_timeout", 0, 1);
  endtask

  task automatic b_wait(input int dly);
    bit done = 0;
    logic prev = cpu_reset;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (s_axi_bvalid) begin b_cpu_prev = prev; b_cpu_now = cpu_reset; done = 1; end
      else prev = cpu_reset;
    end
    if (!done) begin chk("b_timeout", 0, 1); return; end
    repeat (dly) @(negedge clk);
    chk("bresp", s_axi_bresp, 2'b00);
    s_axi_bready = 1'b1;
    @(posedge clk); #1 s_axi_bready = 1'b0;
  endtask

  task automatic r_wait(input int dly, output logic [31:0] data);
    bit done = 0;
    data = 'x;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (s_axi_rvalid) done = 1;
    end
    if (!done) begin chk("r_timeout", 0, 1); return; end
    repeat (dly) @(negedge clk);
    data = s_axi_rdata;
    chk("rresp", s_axi_rresp, 2'b00);
    s_axi_rready = 1'b1;
    @(posedge clk); #1 s_axi_rready = 1'b0;
  endtask

  task automatic axi_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int bd);
    fork
      begin repeat (awd) @(posedge clk); #1 aw_hs(a); end
      begin repeat (wd) @(posedge clk); #1 w_hs(d, s); end
    join
    b_wait(bd);
    ref_write(a, d, s);
  endtask

  task automatic axi_read(input logic [13:0] a, input int dly, input string tag,
                          output logic [31:0] got);
    ar_hs(a);
    r_wait(dly, got);
    chk(tag, got, ref_read(a));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, rec;
    logic [13:0] a;
    int we0;
    bit stable;

    repeat (2) @(negedge clk);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_wr_en", bram_wr_en, 0);
    chk("rst_din", bram_din, 0);
    chk("rst_addr", shared_bram_addr, 0);
    reset = 1'b0;
    #1 chk("ready_before_edge", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);

    // Write and read contend right after reset: write must go first.
    fork
      axi_write(14'h0000, 32'h0000_0013, 4'hf, 0, 0, 0);
      axi_read(14'h0000, 0, "rd_after_wr", got);
    join
    chk("first_rd", got, 32'h0000_0013);
    chk("arb_write_first", aw_t < ar_t, 1);

    // Single-lane strobe into dmem quarter 3 base.
    we0 = we_cnt;
    axi_write(14'h1C00, 32'hAABB_CCDD, 4'b0010, 0, 0, 1);
    chk("strb_we_count", we_cnt - we0, 1);
    chk("strb_we_lanes", last_we, 4'b0010);
    axi_read(14'h1C00, 0, "strb_rd", got);
    chk("strb_rd_const", got, 32'h0000_CC00);

    // W arrives well ahead of AW: nothing may be written until AW lands.
    we0 = we_cnt;
    fork
      axi_write(14'h0008, 32'h1122_3344, 4'hf, 6, 0, 0);
      begin
        repeat (5) @(negedge clk);
        chk("wfirst_no_we", we_cnt - we0, 0);
        chk("wfirst_no_b", s_axi_bvalid, 0);
      end
    join
    chk("wfirst_we_once", we_cnt - we0, 1);
    axi_read(14'h000B, 0, "wfirst_rd", got);

    // CTRL register behaviour.
    we0 = we_cnt;
    axi_write(14'h2000, 32'h0, 4'hf, 0, 0, 0);
    chk("ctrl_during_issue", b_cpu_prev, 1);
    chk("ctrl_fall", b_cpu_now, 0);
    axi_read(14'h2000, 0, "ctrl_rd0", got);
    chk("ctrl_rd0_const", got, 0);
    axi_write(14'h2000, 32'h1, 4'h0, 0, 0, 0);
    chk("ctrl_nostrb_cpu", cpu_reset, 0);
    axi_read(14'h2000, 0, "ctrl_nostrb_rd", got);
    axi_write(14'h2004, 32'hffff_ffff, 4'hf, 0, 0, 0);
    chk("ctrl_other_cpu", cpu_reset, 0);
    axi_read(14'h2004, 0, "ctrl_other_rd", got);
    chk("ctrl_no_bram_we", we_cnt - we0, 0);

    // Randomized traffic against the reference.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0)
        a = 14'h2000 | 14'($urandom_range(0, 1) * 4) | 14'($urandom_range(0, 3));
      else
        a = ($urandom_range(0, 1) ? 14'h1000 : 14'h0000) |
            14'($urandom_range(0, 15) << 2) | 14'($urandom_range(0, 3));
      if ($urandom_range(0, 1)) begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        chk("rand_cpu_reset", cpu_reset, ref_ctrl);
      end else begin
        axi_read(a, $urandom_range(0, 3), "rand_rd", got);
      end
    end

    // Long rready stall, then reset in the middle of it.
    axi_write(14'h2000, 32'h0, 4'h1, 0, 0, 0);
    ar_hs(14'h1C00);
    stable = 0;
    rec = 'x;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_axi_rvalid) begin stable = 1; break; end
    end
    if (stable) begin
      rec = s_axi_rdata;
      repeat (10) begin
        @(negedge clk);
        if (!s_axi_rvalid || s_axi_rdata !== rec) stable = 0;
      end
    end
    chk("r_stall_stable", stable, 1);
    chk("r_stall_data", rec, ref_read(14'h1C00));
    reset = 1'b1;
    #1;
    chk("mid_rst_rvalid", s_axi_rvalid, 0);
    chk("mid_rst_cpu_reset", cpu_reset, 1);
    chk("mid_rst_bvalid", s_axi_bvalid, 0);
    ref_ctrl = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    axi_read(14'h1C00, 0, "post_rst_rd", got);
    axi_read(14'h2000, 0, "post_rst_ctrl", got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
